// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART core.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned SAMPLE_LO  = 7;
  localparam int unsigned SAMPLE_HI  = 9;

  // Mode 3 is reserved and behaves as no parity.
  function automatic parity_e to_parity(input logic [1:0] m);
    case (m)
      2'd1:    return PAR_EVEN;
      2'd2:    return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// First-word fall-through FIFO; push while full succeeds only with a same-cycle pop.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   LVL_ONE = 1;
  localparam logic [AW:0]   LVL_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      lvl_q;
  logic             do_push, do_pop;

  assign empty_o    = (lvl_q == '0);
  assign full_o     = (lvl_q == LVL_MAX);
  assign level_o    = lvl_q;
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);
  assign pop_data_o = empty_o ? '0 : mem_q[rd_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_ONE;
      if (do_pop)  rd_q <= rd_q + PTR_ONE;
      if (do_push && !do_pop)      lvl_q <= lvl_q + LVL_ONE;
      else if (!do_push && do_pop) lvl_q <= lvl_q - LVL_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

endmodule

// File: rtl/uart_core_v2.sv
// Full-duplex UART: shared oversample tick, FIFO-buffered TX/RX FSMs, sticky error flags.
module uart_core_v2
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  input  logic [DATA_W-1:0]             tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [DATA_W-1:0]             rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  input  logic                          RX,
  output logic                          TX,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          err_frame,
  output logic                          err_parity,
  output logic                          err_overrun,
  output logic                          err_break,
  input  logic                          err_clear
);

  localparam logic [DIV_W-1:0] DIV_ONE = 1;

  logic [DIV_W-1:0] div_cnt_q;
  logic             tick;

  assign tick = (div_cnt_q == cfg_div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   div_cnt_q <= '0;
    else if (div_cnt_q >= cfg_div) div_cnt_q <= '0;
    else                          div_cnt_q <= div_cnt_q + DIV_ONE;
  end

  logic              tx_pop, tx_empty, tx_full;
  logic [DATA_W-1:0] tx_head;

  assign tx_ready = !tx_full;

  uart_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n),
    .push_i(tx_valid && tx_ready), .push_data_i(tx_data),
    .pop_i(tx_pop), .pop_data_o(tx_head),
    .full_o(tx_full), .empty_o(tx_empty), .level_o(tx_level)
  );

  tx_state_e         tx_state_q, tx_state_d;
  logic [4:0]        tx_tcnt_q, tx_tcnt_d, tx_last;
  logic [3:0]        tx_bit_q, tx_bit_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic              tx_par_q, tx_par_d, tx_stop2_q, tx_stop2_d, tx_q, tx_d;
  parity_e           tx_pmode_q, tx_pmode_d;

  assign tx_last = (tx_state_q == TX_STOP && tx_stop2_q) ? 5'(2*OVERSAMPLE-1) : 5'(OVERSAMPLE-1);
  assign TX      = tx_q;
  assign tx_busy = (tx_state_q != TX_IDLE) || !tx_empty;

  // TX is registered from next-state values so the line moves on the same edge as the FSM.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_pmode_d = tx_pmode_q;
    tx_stop2_d = tx_stop2_q;
    tx_pop     = 1'b0;
    if (tick) begin
      if (tx_state_q == TX_IDLE) begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_state_d = TX_START;
          tx_tcnt_d  = '0;
          tx_shift_d = tx_head;
          tx_pmode_d = to_parity(cfg_parity);
          tx_stop2_d = cfg_stop2;
          tx_par_d   = (^tx_head) ^ (to_parity(cfg_parity) == PAR_ODD);
        end
      end else if (tx_tcnt_q != tx_last) begin
        tx_tcnt_d = tx_tcnt_q + 5'd1;
      end else begin
        tx_tcnt_d = '0;
        case (tx_state_q)
          TX_START: begin
            tx_state_d = TX_DATA;
            tx_bit_d   = '0;
          end
          TX_DATA: begin
            tx_shift_d = {1'b0, tx_shift_q[DATA_W-1:1]};
            if (tx_bit_q == 4'(DATA_W-1))
              tx_state_d = (tx_pmode_q == PAR_NONE) ? TX_STOP : TX_PARITY;
            else
              tx_bit_d = tx_bit_q + 4'd1;
          end
          TX_PARITY: tx_state_d = TX_STOP;
          default:   tx_state_d = TX_IDLE;
        endcase
      end
    end
    case (tx_state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = tx_shift_d[0];
      TX_PARITY: tx_d = tx_par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_tcnt_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_pmode_q <= PAR_NONE;
      tx_stop2_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_pmode_q <= tx_pmode_d;
      tx_stop2_q <= tx_stop2_d;
      tx_q       <= tx_d;
    end
  end

  logic [1:0]        sync_q, rx_vote_q, rx_vote_d;
  logic              rx_s, maj;
  rx_state_e         rx_state_q, rx_state_d;
  logic [3:0]        rx_tcnt_q, rx_tcnt_d, rx_tinc, rx_bit_q, rx_bit_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic              rx_par_q, rx_par_d;
  parity_e           rx_pmode_q, rx_pmode_d;
  logic              rx_push, rx_pop, rx_full, rx_empty;
  logic              set_frame, set_parity, set_break, set_overrun;

  assign rx_s    = sync_q[1];
  assign rx_tinc = rx_tcnt_q + 4'd1;
  assign maj     = (rx_vote_q[0] & rx_vote_q[1]) | (rx_vote_q[0] & rx_s) | (rx_vote_q[1] & rx_s);
  assign rx_valid = !rx_empty;
  assign rx_pop   = rx_valid && rx_ready;
  assign set_overrun = rx_push && rx_full && !rx_pop;

  // State labels advance at the decision tick; the 4-bit tick counter keeps the bit phase.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tcnt_d  = rx_tcnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_pmode_d = rx_pmode_q;
    rx_vote_d  = rx_vote_q;
    rx_push    = 1'b0;
    set_frame  = 1'b0;
    set_parity = 1'b0;
    set_break  = 1'b0;
    if (tick) begin
      if (rx_state_q == RX_IDLE) begin
        if (!rx_s) begin
          rx_state_d = RX_START;
          rx_tcnt_d  = '0;
          rx_pmode_d = to_parity(cfg_parity);
        end
      end else begin
        rx_tcnt_d = rx_tinc;
        if (rx_tinc == 4'(SAMPLE_LO))   rx_vote_d[0] = rx_s;
        if (rx_tinc == 4'(SAMPLE_LO+1)) rx_vote_d[1] = rx_s;
        if (rx_tinc == 4'(SAMPLE_HI)) begin
          case (rx_state_q)
            RX_START: begin
              rx_state_d = maj ? RX_IDLE : RX_DATA;
              rx_bit_d   = '0;
            end
            RX_DATA: begin
              rx_shift_d = {maj, rx_shift_q[DATA_W-1:1]};
              if (rx_bit_q == 4'(DATA_W-1))
                rx_state_d = (rx_pmode_q == PAR_NONE) ? RX_STOP : RX_PARITY;
              else
                rx_bit_d = rx_bit_q + 4'd1;
            end
            RX_PARITY: begin
              rx_par_d   = maj;
              rx_state_d = RX_STOP;
            end
            default: begin
              rx_state_d = RX_IDLE;
              if (!maj) begin
                set_frame = 1'b1;
                set_break = (rx_shift_q == '0) && (rx_pmode_q == PAR_NONE || !rx_par_q);
              end else begin
                rx_push    = 1'b1;
                set_parity = (rx_pmode_q != PAR_NONE) &&
                             (rx_par_q != ((^rx_shift_q) ^ (rx_pmode_q == PAR_ODD)));
              end
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '1;
      rx_state_q  <= RX_IDLE;
      rx_tcnt_q   <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_par_q    <= 1'b0;
      rx_pmode_q  <= PAR_NONE;
      rx_vote_q   <= '1;
      err_frame   <= 1'b0;
      err_parity  <= 1'b0;
      err_overrun <= 1'b0;
      err_break   <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], RX};
      rx_state_q  <= rx_state_d;
      rx_tcnt_q   <= rx_tcnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_par_q    <= rx_par_d;
      rx_pmode_q  <= rx_pmode_d;
      rx_vote_q   <= rx_vote_d;
      err_frame   <= (err_frame   && !err_clear) || set_frame;
      err_parity  <= (err_parity  && !err_clear) || set_parity;
      err_overrun <= (err_overrun && !err_clear) || set_overrun;
      err_break   <= (err_break   && !err_clear) || set_break;
    end
  end

  uart_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n),
    .push_i(rx_push), .push_data_i(rx_shift_q),
    .pop_i(rx_pop), .pop_data_o(rx_data),
    .full_o(rx_full), .empty_o(rx_empty), .level_o(rx_level)
  );

endmodule

// File: tb/tb_uart_core_v2.sv
// Directed self-checking bench for uart_core_v2 (DATA_W=8, FIFO_DEPTH=16).
module tb_uart_core_v2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cfg_div;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;
  logic        RX, TX, tx_busy;
  logic [4:0]  tx_level, rx_level;
  logic        err_frame, err_parity, err_overrun, err_break, err_clear;
  logic        loop, rx_drv;
  int          total = 0;
  int          bad = 0;

  assign RX = loop ? TX : rx_drv;

  always #5 clk = ~clk;

  uart_core_v2 #(.DATA_W(8), .FIFO_DEPTH(16), .DIV_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_div(cfg_div), .cfg_parity(cfg_parity),
    .cfg_stop2(cfg_stop2), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .RX(RX), .TX(TX),
    .tx_busy(tx_busy), .tx_level(tx_level), .rx_level(rx_level),
    .err_frame(err_frame), .err_parity(err_parity), .err_overrun(err_overrun),
    .err_break(err_break), .err_clear(err_clear)
  );

  task automatic push(input logic [7:0] d);
    int n = 0;
    while (!tx_ready && n < 500) begin @(negedge clk); n++; end
    total++;
    if (tx_ready !== 1'b1) begin bad++; $display("FAIL push_ready: got %b want 1", tx_ready); end
    tx_data = d; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic pop();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic clear_errs();
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
  endtask

  task automatic flush_rx();
    int n = 0;
    while (rx_valid && n < 40) begin pop(); n++; end
  endtask

  task automatic wait_tx_low(input int lim);
    int n = 0;
    while (TX === 1'b1 && n < lim) begin @(negedge clk); n++; end
    total++;
    if (TX !== 1'b0) begin bad++; $display("FAIL tx_start_timeout: got TX=%b want 0", TX); end
  endtask

  task automatic wait_rx(input int lim);
    int n = 0;
    while (!rx_valid && n < lim) begin @(negedge clk); n++; end
    total++;
    if (rx_valid !== 1'b1) begin bad++; $display("FAIL rx_valid_timeout: got %b want 1", rx_valid); end
  endtask

  // Drives one 8N frame at 16 clks/bit; gb selects a data bit whose middle clk is flipped.
  task automatic drive_frame(input logic [7:0] d, input bit has_par, input bit par,
                             input bit stop, input int gb);
    rx_drv = 1'b0; repeat (16) @(negedge clk);
    for (int j = 0; j < 8; j++)
      for (int c = 0; c < 16; c++) begin
        rx_drv = (j == gb && c == 8) ? ~d[j] : d[j];
        @(negedge clk);
      end
    if (has_par) begin rx_drv = par; repeat (16) @(negedge clk); end
    rx_drv = stop; repeat (16) @(negedge clk);
    rx_drv = 1'b1; repeat (20) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_div = '0; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0; err_clear = 1'b0;
    loop = 1'b1; rx_drv = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (TX !== 1'b1) begin bad++; $display("FAIL rst_tx: got %b want 1", TX); end
    total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", tx_busy); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", tx_ready); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rst_rxvalid: got %b want 0", rx_valid); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rst_rxdata: got %h want 00", rx_data); end
    total++; if ({tx_level, rx_level} !== 10'd0) begin bad++; $display("FAIL rst_levels: got %0d/%0d want 0/0", tx_level, rx_level); end
    total++; if ({err_frame, err_parity, err_overrun, err_break} !== 4'b0) begin bad++; $display("FAIL rst_errs: got %b want 0000", {err_frame, err_parity, err_overrun, err_break}); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_tx_frame();
    logic [9:0] exp = {1'b1, 8'hA5, 1'b0};
    push(8'hA5);
    wait_tx_low(40);
    for (int o = 0; o < 160; o++) begin
      if (o % 16 == 8 || o == 15 || o == 16) begin
        total++;
        if (TX !== exp[o/16]) begin bad++; $display("FAIL a5_bit@%0d: got %b want %b", o, TX, exp[o/16]); end
      end
      @(negedge clk);
    end
    wait_rx(100);
    total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL a5_rx: got %h want a5", rx_data); end
    total++; if ({err_frame, err_parity, err_overrun, err_break} !== 4'b0) begin bad++; $display("FAIL a5_errs: got %b want 0000", {err_frame, err_parity, err_overrun, err_break}); end
    pop();
  endtask

  task automatic test_parity();
    for (int m = 1; m <= 2; m++) begin
      cfg_parity = 2'(m);
      push(8'h07);
      wait_tx_low(40);
      for (int o = 0; o < 176; o++) begin
        if (o == 152) begin
          total++;
          if (TX !== (m == 1)) begin bad++; $display("FAIL par_bit_m%0d: got %b want %b", m, TX, m == 1); end
        end
        if (o == 168) begin
          total++;
          if (TX !== 1'b1) begin bad++; $display("FAIL par_stop_m%0d: got %b want 1", m, TX); end
        end
        @(negedge clk);
      end
      wait_rx(100);
      total++; if (rx_data !== 8'h07) begin bad++; $display("FAIL par_rx_m%0d: got %h want 07", m, rx_data); end
      total++; if (err_parity !== 1'b0) begin bad++; $display("FAIL par_noerr_m%0d: got %b want 0", m, err_parity); end
      pop();
    end
    loop = 1'b0; cfg_parity = 2'd1;
    drive_frame(8'h07, 1'b1, 1'b0, 1'b1, -1);
    wait_rx(50);
    total++; if (rx_data !== 8'h07) begin bad++; $display("FAIL par_inj_rx: got %h want 07", rx_data); end
    total++; if (err_parity !== 1'b1) begin bad++; $display("FAIL par_inj_err: got %b want 1", err_parity); end
    pop();
    clear_errs();
    total++; if (err_parity !== 1'b0) begin bad++; $display("FAIL par_clear: got %b want 0", err_parity); end
    cfg_parity = 2'd0; loop = 1'b1;
  endtask

  task automatic test_overrun();
    int n = 0;
    for (int i = 1; i <= 17; i++) push(8'(8'h10 + i));
    while (tx_busy && n < 4000) begin @(negedge clk); n++; end
    total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL ovr_busy_timeout: got %b want 0", tx_busy); end
    repeat (30) @(negedge clk);
    total++; if (rx_level !== 5'd16) begin bad++; $display("FAIL ovr_level: got %0d want 16", rx_level); end
    total++; if (err_overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag: got %b want 1", err_overrun); end
    for (int i = 1; i <= 16; i++) begin
      total++;
      if (rx_valid !== 1'b1 || rx_data !== 8'(8'h10 + i)) begin
        bad++; $display("FAIL ovr_pop%0d: got %b/%h want 1/%h", i, rx_valid, rx_data, 8'(8'h10 + i));
      end
      pop();
    end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL ovr_empty: got %b want 0", rx_valid); end
    clear_errs();
  endtask

  task automatic test_break();
    loop = 1'b0; rx_drv = 1'b0;
    repeat (320) @(negedge clk);
    total++; if (err_break !== 1'b1) begin bad++; $display("FAIL brk_flag: got %b want 1", err_break); end
    total++; if (err_frame !== 1'b1) begin bad++; $display("FAIL brk_frame: got %b want 1", err_frame); end
    total++; if (rx_level !== 5'd0) begin bad++; $display("FAIL brk_level: got %0d want 0", rx_level); end
    rx_drv = 1'b1;
    repeat (200) @(negedge clk);
    flush_rx();
    clear_errs();
    total++; if ({err_frame, err_break} !== 2'b00) begin bad++; $display("FAIL brk_clear: got %b want 00", {err_frame, err_break}); end
    drive_frame(8'h55, 1'b0, 1'b0, 1'b0, -1);
    total++; if (err_frame !== 1'b1) begin bad++; $display("FAIL stop0_frame: got %b want 1", err_frame); end
    total++; if (err_break !== 1'b0) begin bad++; $display("FAIL stop0_break: got %b want 0", err_break); end
    total++; if (rx_level !== 5'd0) begin bad++; $display("FAIL stop0_level: got %0d want 0", rx_level); end
    clear_errs();
  endtask

  task automatic test_glitch();
    rx_drv = 1'b0; @(negedge clk); rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    rx_drv = 1'b0; repeat (6) @(negedge clk); rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    total++; if (rx_level !== 5'd0) begin bad++; $display("FAIL glitch_level: got %0d want 0", rx_level); end
    total++; if ({err_frame, err_parity, err_overrun, err_break} !== 4'b0) begin bad++; $display("FAIL glitch_errs: got %b want 0000", {err_frame, err_parity, err_overrun, err_break}); end
    drive_frame(8'h3C, 1'b0, 1'b0, 1'b1, 2);
    wait_rx(50);
    total++; if (rx_data !== 8'h3C) begin bad++; $display("FAIL vote_rx: got %h want 3c", rx_data); end
    total++; if (err_frame !== 1'b0) begin bad++; $display("FAIL vote_frame: got %b want 0", err_frame); end
    pop();
    loop = 1'b1;
  endtask

  task automatic test_baud();
    int n = 0;
    cfg_div = 16'd2;
    push(8'h69);
    wait_tx_low(100);
    while (TX === 1'b0 && n < 200) begin @(negedge clk); n++; end
    total++; if (n != 48) begin bad++; $display("FAIL baud_start_len: got %0d want 48", n); end
    wait_rx(800);
    total++; if (rx_data !== 8'h69) begin bad++; $display("FAIL baud_rx: got %h want 69", rx_data); end
    pop();
    repeat (60) @(negedge clk);
    cfg_div = 16'd0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    cfg_stop2 = 1'b1;
    push(8'hFF);
    push(8'hFF);
    wait_tx_low(40);
    for (int o = 0; o < 178; o++) begin
      if (o == 50) cfg_stop2 = 1'b0;
      if (o == 150 || o == 161 || o == 176) begin
        total++;
        if (TX !== 1'b1) begin bad++; $display("FAIL b2b_stop@%0d: got %b want 1", o, TX); end
      end
      @(negedge clk);
    end
    total++; if (TX !== 1'b0) begin bad++; $display("FAIL b2b_next_start: got %b want 0", TX); end
    for (int k = 0; k < 2; k++) begin
      wait_rx(300);
      total++; if (rx_data !== 8'hFF) begin bad++; $display("FAIL b2b_rx%0d: got %h want ff", k, rx_data); end
      pop();
    end
  endtask

  task automatic test_reset_mid();
    bit stale = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(8'h11 + i));
    wait_tx_low(40);
    repeat (40) @(negedge clk);
    total++; if (tx_level !== 5'd3) begin bad++; $display("FAIL mid_level: got %0d want 3", tx_level); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (TX !== 1'b1) begin bad++; $display("FAIL mid_tx: got %b want 1", TX); end
    total++; if (tx_level !== 5'd0) begin bad++; $display("FAIL mid_txlevel: got %0d want 0", tx_level); end
    total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", tx_busy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int o = 0; o < 300; o++) begin
      if (TX !== 1'b1) stale = 1'b1;
      @(negedge clk);
    end
    total++; if (stale) begin bad++; $display("FAIL mid_stale: got TX low want idle"); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b want 1", tx_ready); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL mid_rxvalid: got %b want 0", rx_valid); end
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_parity();
    test_overrun();
    test_break();
    test_glitch();
    test_baud();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
